// File: rtl/load_scheduler_pkg.sv
// Shared definitions for the load scheduler: channel indices, per-channel FSM
// encodings and counter sizing helpers.
package load_scheduler_pkg;

  localparam int N_CH     = 5;
  localparam int CH_HEAT  = 0;
  localparam int CH_COOL  = 1;
  localparam int CH_PUMP  = 2;
  localparam int CH_SPRNK = 3;
  localparam int CH_EXT   = 4;

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_ON_MIN = 2'b01,
    ST_ON     = 2'b10,
    ST_COOL   = 2'b11
  } chan_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Counter holds values up to max(a,b)-1; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (clog2(m) < 1) ? 1 : clog2(m);
  endfunction

endpackage

// File: rtl/load_scheduler_if.sv
// Request/grant bundle between the utility controllers and the load scheduler.
interface load_scheduler_if
  import load_scheduler_pkg::*;
#(
  parameter int N_REQ = N_CH
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] prio;
  logic             fire;
  logic [N_REQ-1:0] grant;
  logic [2:0]       n_on;
  logic [N_REQ-1:0] denied;
  logic             shed;

  modport master (output req, prio, fire, input grant, n_on, denied, shed);
  modport slave  (input req, prio, fire, output grant, n_on, denied, shed);
endinterface

// File: rtl/load_scheduler_lsch_channel.sv
// One load channel: OFF -> ON_MIN -> ON -> COOL -> OFF with a shared down-counter
// for minimum on-time and restart cooldown.
module lsch_channel
  import load_scheduler_pkg::*;
#(
  parameter int MIN_ON   = 8,
  parameter int COOLDOWN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pick_i,
  input  logic fire_i,
  input  logic req_i,
  output logic grant_o,
  output logic eligible_o
);
  localparam int            CW        = cnt_width(MIN_ON, COOLDOWN);
  localparam logic [CW-1:0] MIN_LOAD  = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN - 1);

  chan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant_q, grant_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (pick_i) begin
          state_d = ST_ON_MIN;
          cnt_d   = MIN_LOAD;
        end
      end
      ST_ON_MIN: begin
        // Last min-on cycle releases directly if the request is gone,
        // so a dropped request holds the grant exactly MIN_ON cycles.
        if (fire_i || (cnt_q == '0 && !req_i)) begin
          state_d = ST_COOL;
          cnt_d   = COOL_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ON: begin
        if (fire_i || !req_i) begin
          state_d = ST_COOL;
          cnt_d   = COOL_LOAD;
        end
      end
      ST_COOL: begin
        // Cooldown restarts while the alarm is active, so it runs after fire clears.
        if (fire_i) begin
          cnt_d = COOL_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
    grant_d = (state_d == ST_ON_MIN) || (state_d == ST_ON);
  end

  assign grant_o    = grant_q;
  assign eligible_o = (state_q == ST_OFF) && req_i && !fire_i;

endmodule

// File: rtl/load_scheduler.sv
// Load scheduler top: exclusion mask, priority/round-robin picker with a
// concurrent-load budget, fire shedding and one-cycle denied/shed pulses.
module load_scheduler
  import load_scheduler_pkg::*;
#(
  parameter int N_REQ    = N_CH,
  parameter int MAX_ON   = 2,
  parameter int MIN_ON   = 8,
  parameter int COOLDOWN = 4,
  parameter int EXCL_A   = CH_HEAT,
  parameter int EXCL_B   = CH_COOL
) (
  input logic             clk,
  input logic             reset,
  load_scheduler_if.slave bus
);
  localparam int RW = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ);

  logic [N_REQ-1:0] chan_elig, chan_grant, excl_mask, cand, hi_cand, pool, pick;
  logic [N_REQ-1:0] denied_q, denied_d;
  logic [RW-1:0]    rr_q, rr_d;
  logic             shed_q, shed_d;
  logic [2:0]       n_on;

  for (genvar g = 0; g < N_REQ; g++) begin : g_ch
    lsch_channel #(
      .MIN_ON  (MIN_ON),
      .COOLDOWN(COOLDOWN)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .pick_i    (pick[g]),
      .fire_i    (bus.fire),
      .req_i     (bus.req[g]),
      .grant_o   (chan_grant[g]),
      .eligible_o(chan_elig[g])
    );
  end

  always_comb begin
    n_on = '0;
    for (int i = 0; i < N_REQ; i++) n_on = n_on + 3'(chan_grant[i]);
  end

  always_comb begin
    excl_mask         = '0;
    excl_mask[EXCL_A] = chan_grant[EXCL_B];
    excl_mask[EXCL_B] = chan_grant[EXCL_A];
  end

  // High-priority candidates form their own class; round-robin within the class.
  always_comb begin : p_pick
    int   idx;
    logic found;
    cand    = chan_elig & ~excl_mask;
    hi_cand = cand & bus.prio;
    pool    = (|hi_cand) ? hi_cand : cand;
    pick    = '0;
    rr_d    = rr_q;
    found   = 1'b0;
    idx     = 0;
    if (n_on < 3'(MAX_ON)) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!found && pool[idx]) begin
          found     = 1'b1;
          pick[idx] = 1'b1;
          rr_d      = (idx == N_REQ - 1) ? '0 : RW'(idx + 1);
        end
      end
    end
  end

  // Exclusion-blocked requesters count as losers too.
  assign denied_d = chan_elig & ~pick;
  assign shed_d   = bus.fire && (|chan_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q     <= '0;
      denied_q <= '0;
      shed_q   <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      denied_q <= denied_d;
      shed_q   <= shed_d;
    end
  end

  assign bus.grant  = chan_grant;
  assign bus.n_on   = n_on;
  assign bus.denied = denied_q;
  assign bus.shed   = shed_q;

endmodule

// File: tb/tb_load_scheduler.sv
// Directed bench for load_scheduler: min-on, cooldown, budget, exclusion,
// priority, fire shedding and async reset.
module tb_load_scheduler;
  import load_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  load_scheduler_if #(.N_REQ(5)) bus ();

  load_scheduler #(
    .N_REQ(5), .MAX_ON(2), .MIN_ON(8), .COOLDOWN(4), .EXCL_A(0), .EXCL_B(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.req  = '0;
    bus.prio = '0;
    bus.fire = 1'b0;
    reset    = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_grant",  8'(bus.grant),  8'h00);
    check("rst_n_on",   8'(bus.n_on),   8'h00);
    check("rst_denied", 8'(bus.denied), 8'h00);
    check("rst_shed",   8'(bus.shed),   8'h00);

    // 1: single request, min-on hold after request drop, then cooldown
    bus.req = 5'b00001;
    tick();                                  // G
    check("t1_grant", 8'(bus.grant), 8'h01);
    check("t1_n_on",  8'(bus.n_on),  8'h01);
    tick(2);                                 // G+2
    bus.req = 5'b00000;
    tick(5);                                 // G+7
    check("t1_min_on_hold", 8'(bus.grant), 8'h01);
    tick();                                  // G+8
    check("t1_release", 8'(bus.grant), 8'h00);
    tick();                                  // G+9
    bus.req = 5'b00001;
    tick(3);                                 // G+12
    check("t1_cooldown_block", 8'(bus.grant),  8'h00);
    check("t1_cool_no_deny",   8'(bus.denied), 8'h00);
    tick();                                  // G+13
    check("t1_regrant", 8'(bus.grant), 8'h01);

    // 2: three simultaneous requests, budget of two
    do_reset();
    bus.req = 5'b11100;
    tick();
    check("t2_grant_a",  8'(bus.grant),  8'h04);
    check("t2_denied_a", 8'(bus.denied), 8'h18);
    tick();
    check("t2_grant_b",  8'(bus.grant),  8'h0C);
    check("t2_denied_b", 8'(bus.denied), 8'h10);
    tick();
    check("t2_n_on_full", 8'(bus.n_on),   8'h02);
    check("t2_denied_c",  8'(bus.denied), 8'h10);
    tick(3);
    check("t2_grant_hold", 8'(bus.grant), 8'h0C);

    // 3: heat/cool exclusion
    do_reset();
    bus.req = 5'b00011;
    tick();                                  // H
    check("t3_grant_heat", 8'(bus.grant),  8'h01);
    check("t3_denied_a",   8'(bus.denied), 8'h02);
    tick();                                  // H+1
    check("t3_excl_block", 8'(bus.grant),  8'h01);
    check("t3_excl_deny",  8'(bus.denied), 8'h02);
    bus.req = 5'b00010;
    tick(6);                                 // H+7
    check("t3_heat_min_on", 8'(bus.grant), 8'h01);
    tick();                                  // H+8
    check("t3_heat_cool", 8'(bus.grant),  8'h00);
    check("t3_denied_b",  8'(bus.denied), 8'h02);
    tick();                                  // H+9
    check("t3_grant_cool", 8'(bus.grant),  8'h02);
    check("t3_denied_c",   8'(bus.denied), 8'h00);

    // 4: priority class wins a freed slot over the round-robin order
    do_reset();
    bus.req = 5'b00101;
    tick(2);                                 // K
    check("t4_two_on", 8'(bus.grant), 8'h05);
    bus.req  = 5'b11001;
    bus.prio = 5'b10000;
    tick(5);                                 // K+5
    check("t4_full_deny", 8'(bus.denied), 8'h18);
    tick(3);                                 // K+8
    check("t4_freed", 8'(bus.grant), 8'h01);
    tick();                                  // K+9
    check("t4_prio_win",   8'(bus.grant),  8'h11);
    check("t4_denied_low", 8'(bus.denied), 8'h08);
    check("t4_n_on",       8'(bus.n_on),   8'h02);

    // 5: fire during min-on sheds everything, cooldown runs after fire clears
    do_reset();
    bus.req = 5'b00101;
    tick(3);                                 // c+3
    check("t5_pre_fire", 8'(bus.grant), 8'h05);
    bus.fire = 1'b1;
    tick();                                  // c+4
    check("t5_shed_grant", 8'(bus.grant), 8'h00);
    check("t5_shed_pulse", 8'(bus.shed),  8'h01);
    check("t5_shed_n_on",  8'(bus.n_on),  8'h00);
    tick();                                  // c+5
    check("t5_shed_once",    8'(bus.shed),   8'h00);
    check("t5_fire_no_deny", 8'(bus.denied), 8'h00);
    bus.fire = 1'b0;
    tick(4);                                 // c+9
    check("t5_cool_block", 8'(bus.grant), 8'h00);
    tick();                                  // c+10
    check("t5_regrant", 8'(bus.grant), 8'h01);

    // 6: async reset during min-on, no cooldown afterwards
    do_reset();
    bus.req = 5'b00001;
    tick(2);
    check("t6_pre_reset", 8'(bus.grant), 8'h01);
    reset = 1'b1;
    #2;
    check("t6_async_drop", 8'(bus.grant), 8'h00);
    #2;
    reset = 1'b0;
    tick();
    check("t6_regrant", 8'(bus.grant), 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
